// File: rtl/clock_pkg.sv
// clock_pkg: shared mode/alarm-state codes, time limits and BCD helper for the alarm timekeeper
package clock_pkg;
  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_RUN_ALT   = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_e;
  localparam int BCD_W = 4;
  localparam int MAX_ALARMS = 8;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  function automatic logic [2*BCD_W-1:0] to_bcd(input logic [6:0] v);
    return {BCD_W'(v / 7'd10), BCD_W'(v % 7'd10)};
  endfunction
endpackage

// File: rtl/alarm_ring_fsm.sv
// alarm_ring_fsm: IDLE/RINGING/SNOOZED sequencing with ring timeout and snooze countdown
module alarm_ring_fsm
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC = 60
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  input  logic         match,
  input  logic         one_sec,
  input  logic         snooze_button,
  input  logic         dismiss_button,
  input  logic         ring_en,
  output alarm_state_e state,
  output logic         alarm_active
);
  logic [7:0] ring_cnt;
  logic [11:0] snz_cnt;
  assign alarm_active = state == ST_RINGING;
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      ring_cnt <= '0;
      snz_cnt <= '0;
    end else
      case (state)
        ST_IDLE:
          if (match) begin
            state <= ST_RINGING;
            ring_cnt <= '0;
          end
        ST_RINGING:
          if (dismiss_button || !ring_en) state <= ST_IDLE;
          else if (snooze_button) begin
            state <= ST_SNOOZED;
            snz_cnt <= 12'(SNOOZE_MIN * 60);
          end else if (one_sec) begin
            if (ring_cnt == 8'(RING_SEC - 1)) state <= ST_IDLE;
            else ring_cnt <= ring_cnt + 8'd1;
          end
        ST_SNOOZED:
          if (dismiss_button || !ring_en) state <= ST_IDLE;
          else if (one_sec) begin
            if (snz_cnt == 12'd1) begin
              state <= ST_RINGING;
              ring_cnt <= '0;
            end else snz_cnt <= snz_cnt - 12'd1;
          end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: rtl/multi_alarm_timekeeper.sv
// multi_alarm_timekeeper: 24h clock with NUM_ALARMS alarm slots and ring/snooze FSM, BCD outputs.
// Define CLOCK_12H_EN for 12-hour display digits and the pm flag.
module multi_alarm_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC = 60,
  localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [AW-1:0]         alarm_sel,
  input  logic                  hour_button,
  input  logic                  min_button,
  input  logic                  sec_button,
  input  logic                  alarm_en_toggle,
  input  logic                  snooze_button,
  input  logic                  dismiss_button,
  output logic [BCD_W-1:0]      hour_first,
  output logic [BCD_W-1:0]      hour_second,
  output logic [BCD_W-1:0]      min_first,
  output logic [BCD_W-1:0]      min_second,
  output logic [BCD_W-1:0]      sec_first,
  output logic [BCD_W-1:0]      sec_second,
  output logic [3:0]            mode_at,
  output logic                  one_sec,
  output logic                  alarm_active,
  output logic [AW-1:0]         ringing_idx,
  output logic [NUM_ALARMS-1:0] alarm_enabled,
  output logic                  pm
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  if (NUM_ALARMS < 1 || NUM_ALARMS > MAX_ALARMS) begin : g_bad_num_alarms
    $error("NUM_ALARMS out of range");
  end
  logic [CW-1:0] cnt;
  logic [4:0] hr, nxt_hr, shown_hr, disp_hr;
  logic [5:0] mn, sc, nxt_mn, shown_mn, shown_sc;
  logic [4:0] al_hr [NUM_ALARMS];
  logic [5:0] al_mn [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] al_en;
  logic [AW-1:0] sel, hit_idx;
  logic set_time, set_alarm, run, tick, hit, match, ring_en, pm_nx;
  alarm_state_e state;
  assign set_time = mode == MODE_SET_TIME;
  assign set_alarm = mode == MODE_SET_ALARM;
  assign run = !set_time && !set_alarm;
  assign tick = cnt == CW'(TICK_DIV - 1);
  assign one_sec = tick;
  assign sel = int'(alarm_sel) < NUM_ALARMS ? alarm_sel : '0;
  assign nxt_mn = mn == MIN_MAX ? '0 : mn + 6'd1;
  assign nxt_hr = mn == MIN_MAX ? (hr == HOUR_MAX ? '0 : hr + 5'd1) : hr;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (al_en[i] && al_hr[i] == nxt_hr && al_mn[i] == nxt_mn) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
  end
  // alarms are compared against the time the current tick is about to produce
  assign match = tick && run && sc == SEC_MAX && hit;
  assign ring_en = al_en[ringing_idx] ^ (alarm_en_toggle && set_alarm && sel == ringing_idx);
  assign mode_at = {state, mode};
  assign alarm_enabled = al_en;
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      cnt <= '0;
      hr <= '0;
      mn <= '0;
      sc <= '0;
    end else begin
      cnt <= (tick || (set_time && sec_button)) ? '0 : cnt + CW'(1);
      if (set_time) begin
        if (hour_button) hr <= hr == HOUR_MAX ? '0 : hr + 5'd1;
        if (min_button) mn <= mn == MIN_MAX ? '0 : mn + 6'd1;
        if (sec_button) sc <= '0;
      end else if (tick) begin
        sc <= sc == SEC_MAX ? '0 : sc + 6'd1;
        if (sc == SEC_MAX) begin
          mn <= nxt_mn;
          hr <= nxt_hr;
        end
      end
    end
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      al_en <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_hr[i] <= '0;
        al_mn[i] <= '0;
      end
    end else if (set_alarm) begin
      if (hour_button) al_hr[sel] <= al_hr[sel] == HOUR_MAX ? '0 : al_hr[sel] + 5'd1;
      if (min_button) al_mn[sel] <= al_mn[sel] == MIN_MAX ? '0 : al_mn[sel] + 6'd1;
      if (alarm_en_toggle) al_en[sel] <= !al_en[sel];
    end
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) ringing_idx <= '0;
    else if (match && state == ST_IDLE) ringing_idx <= hit_idx;
  assign shown_hr = set_alarm ? al_hr[sel] : hr;
  assign shown_mn = set_alarm ? al_mn[sel] : mn;
  assign shown_sc = set_alarm ? '0 : sc;
`ifdef CLOCK_12H_EN
  assign disp_hr = shown_hr == 5'd0 ? 5'd12 : shown_hr > 5'd12 ? shown_hr - 5'd12 : shown_hr;
  assign pm_nx = shown_hr >= 5'd12;
`else
  assign disp_hr = shown_hr;
  assign pm_nx = 1'b0;
`endif
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      {hour_first, hour_second, min_first, min_second, sec_first, sec_second} <= '0;
      pm <= 1'b0;
    end else begin
      {hour_first, hour_second} <= to_bcd(7'(disp_hr));
      {min_first, min_second} <= to_bcd(7'(shown_mn));
      {sec_first, sec_second} <= to_bcd(7'(shown_sc));
      pm <= pm_nx;
    end
  alarm_ring_fsm #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) u_fsm (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .match(match),
    .one_sec(tick),
    .snooze_button(snooze_button),
    .dismiss_button(dismiss_button),
    .ring_en(ring_en),
    .state(state),
    .alarm_active(alarm_active)
  );
endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// tb_multi_alarm_timekeeper: scoreboard bench against a seconds-of-day reference model
module tb_multi_alarm_timekeeper;
  localparam int TD = 4, NA = 4, SM = 1, RS = 3;
  logic clk_100MHz = 1'b0, reset = 1'b1;
  logic [1:0] mode = '0, alarm_sel = '0;
  logic hour_button = 0, min_button = 0, sec_button = 0, alarm_en_toggle = 0;
  logic snooze_button = 0, dismiss_button = 0;
  logic [3:0] hour_first, hour_second, min_first, min_second, sec_first, sec_second, mode_at;
  logic one_sec, alarm_active, pm;
  logic [1:0] ringing_idx;
  logic [3:0] alarm_enabled;

  multi_alarm_timekeeper #(.TICK_DIV(TD), .NUM_ALARMS(NA), .SNOOZE_MIN(SM), .RING_SEC(RS)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .mode(mode), .alarm_sel(alarm_sel),
    .hour_button(hour_button), .min_button(min_button), .sec_button(sec_button),
    .alarm_en_toggle(alarm_en_toggle), .snooze_button(snooze_button), .dismiss_button(dismiss_button),
    .hour_first(hour_first), .hour_second(hour_second), .min_first(min_first), .min_second(min_second),
    .sec_first(sec_first), .sec_second(sec_second), .mode_at(mode_at), .one_sec(one_sec),
    .alarm_active(alarm_active), .ringing_idx(ringing_idx), .alarm_enabled(alarm_enabled), .pm(pm)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [23:0] dig;
    logic [3:0]  mat;
    logic        os;
    logic        act;
    logic [1:0]  ridx;
    logic [3:0]  en;
    logic        pm;
  } obs_t;

  obs_t act_obs;
  assign act_obs = {hour_first, hour_second, min_first, min_second, sec_first, sec_second,
                    mode_at, one_sec, alarm_active, ringing_idx, alarm_enabled, pm};

  obs_t exp_q[$];
  string tag_q[$];
  string tag = "reset";
  int checks = 0, passed = 0;

  // reference model: time as seconds of day, alarms as minutes of day
  int cnt, tsec, ast, rc, snz, ridx;
  int amin[NA];
  bit aen[NA];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, want);
  endtask

  function automatic logic [23:0] digits(input int h, input int m, input int s);
    int dh = h;
`ifdef CLOCK_12H_EN
    dh = h == 0 ? 12 : h > 12 ? h - 12 : h;
`endif
    return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    cnt = 0; tsec = 0; ast = 0; rc = 0; snz = 0; ridx = 0;
    for (int i = 0; i < NA; i++) begin
      amin[i] = 0;
      aen[i] = 0;
    end
  endtask

  task automatic cyc(input int md, input int sel, input bit hb, input bit mb, input bit sb,
                     input bit tog, input bit sz, input bit ds);
    obs_t e;
    int h, m, s, hidx;
    bit tick, hit;
    mode = 2'(md); alarm_sel = 2'(sel);
    hour_button = hb; min_button = mb; sec_button = sb;
    alarm_en_toggle = tog; snooze_button = sz; dismiss_button = ds;
    if (md == 2) begin
      h = amin[sel] / 60; m = amin[sel] % 60; s = 0;
    end else begin
      h = tsec / 3600; m = tsec / 60 % 60; s = tsec % 60;
    end
    e.dig = digits(h, m, s);
`ifdef CLOCK_12H_EN
    e.pm = h >= 12;
`else
    e.pm = 1'b0;
`endif
    tick = cnt == TD - 1;
    cnt = (tick || (md == 1 && sb)) ? 0 : cnt + 1;
    if (md == 1) begin
      if (hb) tsec = (tsec + 3600) % 86400;
      if (mb) tsec = tsec - tsec % 3600 + (tsec % 3600 + 60) % 3600;
      if (sb) tsec = tsec - tsec % 60;
    end else if (tick) tsec = (tsec + 1) % 86400;
    if (md == 2) begin
      if (hb) amin[sel] = (amin[sel] + 60) % 1440;
      if (mb) amin[sel] = amin[sel] - amin[sel] % 60 + (amin[sel] % 60 + 1) % 60;
      if (tog) aen[sel] = !aen[sel];
    end
    hit = 0; hidx = 0;
    if (tick && (md == 0 || md == 3) && tsec % 60 == 0)
      for (int i = NA - 1; i >= 0; i--)
        if (aen[i] && amin[i] == tsec / 60) begin
          hit = 1; hidx = i;
        end
    case (ast)
      0: if (hit) begin ast = 1; rc = 0; ridx = hidx; end
      1: if (ds || !aen[ridx]) ast = 0;
         else if (sz) begin ast = 2; snz = SM * 60; end
         else if (tick) begin
           if (rc == RS - 1) ast = 0;
           else rc++;
         end
      default: if (ds || !aen[ridx]) ast = 0;
         else if (tick) begin
           snz--;
           if (snz == 0) begin ast = 1; rc = 0; end
         end
    endcase
    e.mat = {2'(ast), 2'(md)};
    e.os = cnt == TD - 1;
    e.act = ast == 1;
    e.ridx = 2'(ridx);
    for (int i = 0; i < NA; i++) e.en[i] = aen[i];
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk_100MHz);
  endtask

  task automatic idle(input int n, input int md);
    repeat (n) cyc(md, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input int md);
    idle(n * TD, md);
  endtask

  task automatic set_time(input int h, input int m);
    repeat ((h - tsec / 3600 + 24) % 24) cyc(1, 0, 1, 0, 0, 0, 0, 0);
    repeat ((m - tsec / 60 % 60 + 60) % 60) cyc(1, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic set_alarm(input int sl, input int h, input int m, input bit en);
    repeat ((h - amin[sl] / 60 + 24) % 24) cyc(2, sl, 1, 0, 0, 0, 0, 0);
    repeat ((m - amin[sl] % 60 + 60) % 60) cyc(2, sl, 0, 1, 0, 0, 0, 0);
    if (aen[sl] != en) cyc(2, sl, 0, 0, 0, 1, 0, 0);
  endtask

  initial forever begin
    @(posedge clk_100MHz);
    #1;
    if (exp_q.size() > 0) chk(tag_q.pop_front(), 64'(act_obs), 64'(exp_q.pop_front()));
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk_100MHz);
    chk("reset_outputs", 64'(act_obs), 64'(0));
    reset = 1'b0;
    tag = "run_wrap";
    ticks(2, 0);
    set_time(23, 59);
    ticks(58, 0);
    ticks(3, 0);
    tag = "alarm_slot1";
    set_alarm(1, 7, 30, 1);
    set_time(7, 29);
    ticks(59, 0);
    ticks(2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    tag = "lowest_idx_snooze";
    set_alarm(0, 6, 0, 1);
    set_alarm(2, 6, 0, 1);
    set_time(5, 59);
    ticks(61, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    ticks(61, 0);
    tag = "dismiss_beats_snooze";
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    ticks(2, 0);
    tag = "ring_timeout";
    set_time(5, 59);
    ticks(64, 0);
    tag = "disable_while_ringing";
    set_time(5, 59);
    ticks(60, 0);
    cyc(2, 0, 0, 0, 0, 1, 0, 0);
    ticks(1, 0);
    set_alarm(0, 6, 0, 1);
    tag = "sec_edit_vs_tick";
    ticks(3, 0);
    while (cnt != TD - 1) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    idle(6, 1);
    tag = "async_reset_ring";
    set_time(5, 59);
    ticks(61, 0);
    chk("ring_before_reset", 64'(alarm_active), 64'(ast == 1));
    #2 reset = 1'b1;
    #1 chk("async_reset_active", 64'(alarm_active), 64'(0));
    chk("async_reset_outputs", 64'(act_obs), 64'(0));
    model_reset();
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    reset = 1'b0;
    tag = "after_reset";
    ticks(2, 0);
    tag = "hour_display";
    set_time(13, 5);
    idle(3, 0);
    set_time(0, 10);
    idle(3, 0);
    tag = "random";
    set_alarm(3, 0, 11, 1);
    repeat (600)
      cyc($urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    @(posedge clk_100MHz);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/multi_alarm_timekeeper.md
Name: multi_alarm_timekeeper

Overview:
Parametrised successor to the single-alarm clock datapath. It keeps 24-hour time, holds NUM_ALARMS independently settable and enabled alarms, and runs a ring/snooze/dismiss state machine with auto-timeout. Outputs are BCD digit pairs plus status. It sits between the debounced button layer and the VGA digit renderer, and drops in where the binary clock sits today.

Parameters:
TICK_DIV, 100000000, clk_100MHz cycles per one-second tick (sim uses 4)
NUM_ALARMS, 4, number of alarm slots (1..8)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_SEC, 60, seconds ringing before auto-dismiss (1..255)

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode  in  2  0=RUN, 1=SET_TIME, 2=SET_ALARM, 3=treated as RUN
alarm_sel  in  $clog2(NUM_ALARMS) (min 1)  alarm slot shown/edited in SET_ALARM
hour_button, min_button, sec_button  in  1 each  single-cycle pulses from debouncer
alarm_en_toggle  in  1  pulse; toggles enable of alarm_sel slot (SET_ALARM only)
snooze_button, dismiss_button  in  1 each  pulses
hour_first, hour_second, min_first, min_second, sec_first, sec_second  out  4 each  BCD; *_first=tens, *_second=units
mode_at  out  4  {alarm_state[1:0], mode[1:0]} for renderer
one_sec  out  1  one-cycle tick pulse
alarm_active  out  1  high while RINGING
ringing_idx  out  $clog2(NUM_ALARMS) (min 1)  slot that fired
alarm_enabled  out  NUM_ALARMS  enable bits
pm  out  1  12h PM flag (see feature)

Behaviour:
- Reset: time 00:00:00, all alarms 00:00 disabled, tick counter 0, state IDLE, ringing_idx 0, all outputs 0 (digits 0).
- Tick: counter 0..TICK_DIV-1. one_sec is asserted on the cycle the counter wraps.
- RUN: one_sec advances sec. 59->0 carries into min, min 59->0 carries into hour, 23:59:59 -> 00:00:00. Buttons ignored.
- SET_TIME: time frozen (ticks do not advance it; one_sec still pulses).
  - hour_button: hour+1 mod 24.
  - min_button: min+1 mod 60, no carry.
  - sec_button: sec=0 and tick counter=0.
- SET_ALARM: digits show alarm[alarm_sel] hh:mm, sec digits 00.
  - hour/min buttons edit that slot (mod 24/60, no carry).
  - alarm_en_toggle flips its enable. sec_button ignored.
  - Time keeps running in the background.
- All button effects land the cycle after the pulse. Output digits are registered; 1-cycle latency from internal state.
- Match: on a one_sec that produces sec==0 while mode is RUN (or 3), compare new hh:mm with every enabled slot. Lowest matching index wins.
- Alarm FSM:
  - IDLE: on match -> RINGING; ring_cnt=0; ringing_idx=match.
  - RINGING:
    - dismiss -> IDLE.
    - else snooze -> SNOOZED, snz_cnt=SNOOZE_MIN*60.
    - else one_sec increments ring_cnt; ring_cnt==RING_SEC-1 at a tick -> IDLE.
  - SNOOZED: one_sec decrements snz_cnt; reaching 0 -> RINGING, ring_cnt=0. dismiss -> IDLE. snooze ignored.
  - Matches are ignored in RINGING/SNOOZED.
  - Clearing the enable of ringing_idx in RINGING/SNOOZED -> IDLE next cycle.
- Simultaneous events:
  - dismiss beats snooze.
  - A disable toggle beats the timeout.
  - A tick and a button edit in SET_TIME: the edit wins.
- Reset mid-ring: immediate IDLE, alarms cleared.
- Alarm state encoding: IDLE=0, RINGING=1, SNOOZED=2.

Optional Feature:
CLOCK_12H_EN:
- Defined: hour digits show 12-hour form (00->12, 13..23 -> 1..11). pm=1 for internal hour 12..23. Internal storage and alarm compare stay 24-hour.
- Undefined: 24-hour digits, pm tied 0.

Decomposition:
- Package clock_pkg: mode codes, alarm-state codes, BCD width constant, max-alarm limit, sec/min/hour limit constants (59, 23).
- One natural sub-module: alarm_ring_fsm (IDLE/RINGING/SNOOZED, ring and snooze counters, dismiss/snooze priority). Inputs: match/one_sec/buttons/enable-of-ringing-slot. Outputs: state and alarm_active.
- Binary-to-BCD split is a function in clock_pkg.

Test Plan:
- Reset, RUN, TICK_DIV=4, time preset to 23:59:58 → after 2 ticks digits read 0,0,0,0,0,0; one_sec asserted every 4th cycle.
- SET_ALARM, alarm_sel=1, 7 hour_button + 30 min_button + alarm_en_toggle, then RUN from 07:29:59 → next tick alarm_active=1, ringing_idx=1, mode_at=4'b0100.
- Slots 0 and 2 both at 06:00 enabled → ringing_idx=0. Snooze with SNOOZE_MIN=1 → RINGING again exactly 60 ticks later.
- RINGING with snooze+dismiss on the same cycle → IDLE, no snooze; RING_SEC=3 without buttons → IDLE after 3 ticks.
- SET_TIME with sec_button and tick on the same cycle → sec=00, counter 0. Async reset asserted mid-RINGING → alarm_active=0 without waiting for a clock edge.
- CLOCK_12H_EN defined, time 13:05 → hour digits 0,1, pm=1; 00:10 → hour digits 1,2, pm=0.
